dot_mac_pipe: RTL and testbench

DOT_MAC_PIPE -- requirements
Module: dot_mac_pipe

---
 rtl/dot_mac_pipe.sv | 112 +++++++++++
 tb/tb_dot_mac_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dot_mac_pipe.sv
// dot_mac_pipe: three-stage unsigned dot-product multiply-accumulate pipeline.
// Stage 1 registers the per-lane products, stage 2 their full-width sum, and
// stage 3 updates the running accumulator that drives out_data.
// Optional feature: define DOT_MAC_PIPE_SAT_EN to saturate the accumulator on
// overflow; without it the accumulator wraps modulo 2^ACC_W. The sticky ovf
// flag behaves the same in both builds.
module dot_mac_pipe #(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int ACC_W = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic [LANES*WIDTH-1:0]   a_vec,
  input  logic [LANES*WIDTH-1:0]   b_vec,
  output logic                     out_valid,
  output logic [ACC_W-1:0]         out_data,
  output logic                     ovf
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int SUM_W  = PROD_W + $clog2(LANES);
  localparam int EXT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

  logic [PROD_W-1:0] prodNext [LANES];
  logic [PROD_W-1:0] prod     [LANES];
  logic              valid1;
  logic              first1;

  logic [SUM_W-1:0]  sumNext;
  logic [SUM_W-1:0]  sum;
  logic              valid2;
  logic              first2;

  logic [EXT_W-1:0]  total;
  logic              overflow;
  logic [ACC_W-1:0]  accNext;
  logic              ovfNext;

  // Slice each lane out of the input vectors and form its full-width product.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prodNext[i] = PROD_W'(a_vec[i*WIDTH +: WIDTH]) * PROD_W'(b_vec[i*WIDTH +: WIDTH]);
    end
  end

  // Stage 1: capture the lane products along with the sample's valid/first tags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) prod[i] <= '0;
      valid1 <= 1'b0;
      first1 <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) prod[i] <= prodNext[i];
      valid1 <= in_valid;
      first1 <= in_first;
    end
  end

  // Add the registered products, widened so the sum can never truncate.
  always_comb begin
    sumNext = '0;
    for (int i = 0; i < LANES; i++) begin
      sumNext = sumNext + SUM_W'(prod[i]);
    end
  end

  // Stage 2: register the lane sum and forward the tags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum    <= '0;
      valid2 <= 1'b0;
      first2 <= 1'b0;
    end else begin
      sum    <= sumNext;
      valid2 <= valid1;
      first2 <= first1;
    end
  end

  // Form the next accumulator value one bit wider than needed, so any carry
  // past ACC_W shows up as an overflow event; a first sample restarts from zero.
  always_comb begin
    total    = (first2 ? EXT_W'(0) : EXT_W'(out_data)) + EXT_W'(sum);
    overflow = |total[EXT_W-1:ACC_W];
`ifdef DOT_MAC_PIPE_SAT_EN
    accNext  = overflow ? {ACC_W{1'b1}} : total[ACC_W-1:0];
`else
    accNext  = total[ACC_W-1:0];
`endif
    ovfNext  = first2 ? overflow : (ovf | overflow);
  end

  // Stage 3: update the accumulator and sticky flag only for valid samples;
  // bubbles leave both untouched so out_data holds between results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= valid2;
      if (valid2) begin
        out_data <= accNext;
        ovf      <= ovfNext;
      end
    end
  end

endmodule

// File: tb/tb_dot_mac_pipe.sv
// tb_dot_mac_pipe: scoreboard bench for dot_mac_pipe (WIDTH=8, LANES=4, ACC_W=20).
// Define DOT_MAC_PIPE_SAT_EN for both bench and RTL to check the saturating build.
module tb_dot_mac_pipe;

  localparam int WIDTH = 8;
  localparam int LANES = 4;
  localparam int ACC_W = 20;
  localparam longint MAXV = (longint'(1) << ACC_W) - 1;

  typedef struct {
    logic [ACC_W-1:0] data;
    logic             ovf;
    int               edgeNo;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_first = 1'b0;
  logic [LANES*WIDTH-1:0] a_vec = '0;
  logic [LANES*WIDTH-1:0] b_vec = '0;
  logic                   out_valid;
  logic [ACC_W-1:0]       out_data;
  logic                   ovf;

  exp_t             expQ[$];
  longint           modelAcc = 0;
  logic             modelOvf = 1'b0;
  logic [ACC_W-1:0] lastData = '0;
  int               cycle = 0;
  int               testsRun = 0;
  int               failures = 0;

  dot_mac_pipe #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(ACC_W)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_first(in_first),
    .a_vec(a_vec),
    .b_vec(b_vec),
    .out_valid(out_valid),
    .out_data(out_data),
    .ovf(ovf)
  );

  // Free-running clock and an edge counter used for latency checks.
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Lane 0 is the first argument and lands in the low byte.
  function automatic logic [LANES*WIDTH-1:0] pack(input int l0, input int l1, input int l2, input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  // Drive one valid vector pair and push the reference result for it.
  task automatic applyStimulus(input logic [LANES*WIDTH-1:0] a, input logic [LANES*WIDTH-1:0] b,
                               input logic first);
    longint sum;
    longint total;
    logic   ovE;
    exp_t   e;
    sum = 0;
    for (int i = 0; i < LANES; i++) sum += longint'(a[i*WIDTH +: WIDTH]) * longint'(b[i*WIDTH +: WIDTH]);
    total = (first ? 0 : modelAcc) + sum;
    ovE = (total > MAXV);
`ifdef DOT_MAC_PIPE_SAT_EN
    modelAcc = ovE ? MAXV : total;
`else
    modelAcc = total & MAXV;
`endif
    modelOvf = first ? ovE : (modelOvf | ovE);
    e.data = modelAcc[ACC_W-1:0];
    e.ovf = modelOvf;
    e.edgeNo = cycle + 1;
    expQ.push_back(e);
    in_valid = 1'b1;
    in_first = first;
    a_vec = a;
    b_vec = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic applyBubble();
    in_valid = 1'b0;
    in_first = 1'b0;
    a_vec = '0;
    b_vec = '0;
    @(posedge clk);
    #1;
  endtask

  // Wait a bounded number of cycles for every expected result to come out.
  task automatic waitDrain();
    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    if (expQ.size() != 0) begin
      checkOutput("drain_pending", expQ.size(), 0);
      expQ.delete();
    end
  endtask

  // Compare each output against the scoreboard; between results out_data must hold.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("data", out_data, e.data);
          checkOutput("ovf", ovf, e.ovf);
          checkOutput("latency", cycle, e.edgeNo + 2);
        end
      end else begin
        checkOutput("hold", out_data, lastData);
      end
      lastData = out_data;
    end
  end

  // Hard stop if something wedges the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [LANES*WIDTH-1:0] va;
    logic [LANES*WIDTH-1:0] vb;
    logic [LANES*WIDTH-1:0] all255;
    va = pack(1, 2, 3, 4);
    vb = pack(5, 6, 7, 8);
    all255 = pack(255, 255, 255, 255);

    // Reset state.
    #2;
    checkOutput("reset_data", out_data, 0);
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_ovf", ovf, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single vector.
    applyStimulus(va, vb, 1'b1);
    waitDrain();

    // Accumulate, bubble, restart.
    applyStimulus(va, vb, 1'b1);
    applyStimulus(va, vb, 1'b0);
    applyStimulus(va, vb, 1'b0);
    applyBubble();
    applyStimulus(pack(0, 0, 0, 1), pack(0, 0, 0, 9), 1'b1);
    waitDrain();

    // Overflow then clear.
    applyStimulus(all255, all255, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(all255, all255, 1'b0);
    applyStimulus(all255, all255, 1'b0);
    applyStimulus(va, vb, 1'b1);
    waitDrain();

    // Lane mapping.
    applyStimulus(pack(0, 0, 200, 0), pack(0, 0, 3, 0), 1'b1);
    waitDrain();

    // Random stream with random restarts and bubbles.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) applyBubble();
      else applyStimulus($urandom, $urandom, ($urandom_range(0, 4) == 0));
    end
    waitDrain();

    // Reset mid-flight: vectors in the pipe are dropped and the flags clear at once.
    applyStimulus(va, vb, 1'b1);
    applyStimulus(va, vb, 1'b0);
    applyStimulus(va, vb, 1'b0);
    applyBubble();
    #1;
    reset = 1'b1;
    expQ.delete();
    modelAcc = 0;
    modelOvf = 1'b0;
    lastData = '0;
    #1;
    checkOutput("midreset_data", out_data, 0);
    checkOutput("midreset_valid", out_valid, 0);
    checkOutput("midreset_ovf", ovf, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    applyStimulus(va, vb, 1'b0);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
